rshift_arbiter: RTL and testbench

RSHIFT_ARBITER -- requirements
Module: rshift_arbiter

---
 rtl/rshift_arbiter.sv | 136 +++++++++++++
 tb/tb_rshift_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rshift_arbiter.sv
// rshift_arbiter: two requesters share one iterative logical right shifter.
// A round-robin arbiter accepts one request at a time. The shifter moves the
// accepted operand right one bit per cycle and fills the vacated MSBs with zeros.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req0/data0/amt0    requester 0 request, operand and shift amount
//   req1/data1/amt1    requester 1 request, operand and shift amount
//   gnt0, gnt1         one-cycle pulse: that requester's operands were accepted
//   busy               high while an operation is in flight
//   done               one-cycle pulse: result/owner just updated
//   result             shifted operand, held until the next done
//   owner              requester ID that produced the current result
module rshift_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AMT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic [AMT_W-1:0]  amt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic [AMT_W-1:0]  amt1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              owner
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] work, work_n;
    logic [DATA_W-1:0] result_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              cur_id, cur_id_n;
    logic              last_owner, last_owner_n;
    logic              gnt0_n, gnt1_n, busy_n, done_n, owner_n;
    logic              pick;
    logic [DATA_W-1:0] pick_data;
    logic [AMT_W-1:0]  pick_amt;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            count      <= '0;
            cur_id     <= 1'b0;
            last_owner <= 1'b1;   // requester 0 wins the first contention
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            owner      <= 1'b0;
        end else begin
            state      <= state_n;
            work       <= work_n;
            count      <= count_n;
            cur_id     <= cur_id_n;
            last_owner <= last_owner_n;
            gnt0       <= gnt0_n;
            gnt1       <= gnt1_n;
            busy       <= busy_n;
            done       <= done_n;
            result     <= result_n;
            owner      <= owner_n;
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_n      = state;
        work_n       = work;
        count_n      = count;
        cur_id_n     = cur_id;
        last_owner_n = last_owner;
        gnt0_n       = 1'b0;
        gnt1_n       = 1'b0;
        done_n       = 1'b0;
        result_n     = result;
        owner_n      = owner;

        // Under contention, grant the requester that did not win last time
        pick      = (req0 && req1) ? ~last_owner : req1;
        pick_data = pick ? data1 : data0;
        pick_amt  = pick ? amt1  : amt0;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_n      = SHIFT;
                    work_n       = pick_data;
                    // Clamp to DATA_W: any larger shift already gives zero
                    count_n      = (32'(pick_amt) >= DATA_W) ? CNT_W'(DATA_W)
                                                             : CNT_W'(pick_amt);
                    cur_id_n     = pick;
                    last_owner_n = pick;
                    gnt0_n       = ~pick;
                    gnt1_n       = pick;
                end
            end
            SHIFT: begin
                if (count != '0) begin
                    work_n  = work >> 1;
                    count_n = count - CNT_W'(1);
                end else begin
                    state_n  = DONE;
                    done_n   = 1'b1;
                    result_n = work;
                    owner_n  = cur_id;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_rshift_arbiter.sv
// Directed testbench for rshift_arbiter. Expected values are computed by hand.
module tb_rshift_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] data0, data1, amt0, amt1;
    logic       gnt0, gnt1, busy, done, owner;
    logic [7:0] result;

    int n_vec = 0;
    int n_bad = 0;

    rshift_arbiter #(.DATA_W(8), .AMT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .amt0(amt0),
        .req1(req1), .data1(data1), .amt1(amt1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .result(result), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it through to done
    task automatic run_one(input bit id, input logic [7:0] d, input logic [7:0] a,
                           input logic [7:0] exp_res, input int exp_lat);
        int n;
        logic g;
        if (id) begin req1 = 1'b1; data1 = d; amt1 = a; end
        else    begin req0 = 1'b1; data0 = d; amt0 = a; end
        step();
        n = 1;
        g = id ? gnt1 : gnt0;
        while (!g && n < 20) begin
            step();
            n++;
            g = id ? gnt1 : gnt0;
        end
        check("gnt_seen", 32'(g), 32'd1);
        check("gnt_lat", 32'(n), 32'd1);
        check("gnt_other", 32'(id ? gnt0 : gnt1), 32'd0);
        check("busy_gnt", 32'(busy), 32'd1);
        // Scramble operands after acceptance; in-flight op must not change
        if (id) begin req1 = 1'b0; data1 = ~d; amt1 = 8'd3; end
        else    begin req0 = 1'b0; data0 = ~d; amt0 = 8'd3; end
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 40);
        check("done_lat", 32'(n), 32'(exp_lat));
        check("result", 32'(result), 32'(exp_res));
        check("owner", 32'(owner), 32'(id));
        check("busy_done", 32'(busy), 32'd1);
        step();
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(exp_res));
    endtask

    initial begin
        int n;
        logic exp_id;

        // Reset held with both requests pending
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        data0 = 8'h00; amt0 = 8'd0; data1 = 8'h00; amt1 = 8'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_gnt0", 32'(gnt0), 32'd0);
            check("rst_gnt1", 32'(gnt1), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_result", 32'(result), 32'd0);
            check("rst_owner", 32'(owner), 32'd0);
        end
        rst = 1'b0;
        step();
        check("first_gnt0", 32'(gnt0), 32'd1);
        check("first_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        n = 0;
        do begin step(); n++; end while (!done && n < 20);
        check("first_done", 32'(done), 32'd1);
        check("first_owner", 32'(owner), 32'd0);
        step();

        // Single-requester transactions
        run_one(1'b0, 8'b10110110, 8'd2,   8'b00101101, 3);
        run_one(1'b1, 8'b10110110, 8'd0,   8'b10110110, 1);
        run_one(1'b0, 8'hFF,       8'd200, 8'h00,       9);
        run_one(1'b1, 8'hC3,       8'd8,   8'h00,       9);
        run_one(1'b0, 8'h81,       8'd7,   8'h01,       8);

        // Round robin with both requests held continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; data0 = 8'h02; amt0 = 8'd1;
        req1 = 1'b1; data1 = 8'h40; amt1 = 8'd1;
        for (int g = 0; g < 4; g++) begin
            exp_id = 1'(g % 2);
            n = 0;
            while (!(gnt0 || gnt1) && n < 20) begin step(); n++; end
            check("rr_gnt0", 32'(gnt0), 32'(!exp_id));
            check("rr_gnt1", 32'(gnt1), 32'(exp_id));
            n = 0;
            do begin
                step(); n++;
                if (gnt0 && gnt1) check("rr_overlap", 32'd1, 32'd0);
            end while (!done && n < 20);
            check("rr_lat", 32'(n), 32'd2);
            check("rr_owner", 32'(owner), 32'(exp_id));
            check("rr_result", 32'(result), exp_id ? 32'h20 : 32'h01);
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        // Abort mid-shift with reset
        req0 = 1'b1; data0 = 8'hAA; amt0 = 8'd7;
        n = 0;
        do begin step(); n++; end while (!gnt0 && n < 20);
        check("abort_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_nodone", 32'(done), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        run_one(1'b1, 8'h80, 8'd7, 8'h01, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
